// File: rtl/pc_next_ctrl_if.sv
// Fetch-control bundle between the PC controller, the EX branch decision and the
// instruction-memory request port.
interface pc_next_ctrl_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            pc_src;
  logic [XLEN-1:0] branch_target;
  logic            imem_ready;
  logic [XLEN-1:0] pc;
  logic            imem_req;
  logic            flush;
  logic            misalign;
  logic [15:0]     redirect_cnt;

  // Handshake: a fetch of pc transfers in any cycle where imem_req && imem_ready.
  // While imem_req is high and not yet accepted, pc is held stable.
  modport master (
    input  stall, pc_src, branch_target, imem_ready,
    output pc, imem_req, flush, misalign, redirect_cnt
  );

  modport slave (
    output stall, pc_src, branch_target, imem_ready,
    input  pc, imem_req, flush, misalign, redirect_cnt
  );
endinterface

// File: rtl/pc_next_ctrl.sv
// Program-counter owner: sequential fetch over valid/ready, branch redirect with
// a fixed-length IF/ID flush window.
module pc_next_ctrl #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC     = '0,
  parameter int              FLUSH_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  pc_next_ctrl_if.master     bus,
  output logic [0:0]         state_o
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;
  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  logic [0:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [3:0]      flush_cnt_q, flush_cnt_d;
  logic            misalign_q, misalign_d;
  logic [15:0]     redirect_cnt_q, redirect_cnt_d;
  logic            imem_req;
  logic            transfer;

  assign imem_req = (state_q == ST_RUN) && !bus.stall && !rst;
  assign transfer = imem_req && bus.imem_ready;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    flush_cnt_d    = flush_cnt_q;
    misalign_d     = 1'b0;
    redirect_cnt_d = redirect_cnt_q;
    case (state_q)
      ST_RUN: begin
        // A redirect discards any fetch of the old pc accepted this same cycle.
        if (bus.pc_src) begin
          pc_d           = {bus.branch_target[XLEN-1:2], 2'b00};
          state_d        = ST_FLUSH;
          flush_cnt_d    = FLUSH_INIT;
          misalign_d     = |bus.branch_target[1:0];
          redirect_cnt_d = redirect_cnt_q + 16'd1;
        end else if (transfer) begin
          pc_d = pc_q + XLEN'(4);
        end
      end
      ST_FLUSH: begin
        // pc_src here comes from a wrong-path instruction and is ignored.
        if (flush_cnt_q == 4'd0) begin
          state_d = ST_RUN;
        end else begin
          flush_cnt_d = flush_cnt_q - 4'd1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_RUN;
      pc_q           <= RESET_PC;
      flush_cnt_q    <= 4'd0;
      misalign_q     <= 1'b0;
      redirect_cnt_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      flush_cnt_q    <= flush_cnt_d;
      misalign_q     <= misalign_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign bus.pc           = pc_q;
  assign bus.imem_req     = imem_req;
  assign bus.flush        = (state_q == ST_FLUSH);
  assign bus.misalign     = misalign_q;
  assign bus.redirect_cnt = redirect_cnt_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_pc_next_ctrl.sv
// Directed bench for pc_next_ctrl: reset, sequential fetch, handshake holds,
// redirects with flush, ignored wrong-path redirects, misalign, wrap, reset in flush.
module tb_pc_next_ctrl;

  logic clk;
  logic rst;
  logic rst_hi;
  logic [0:0] state_lo;
  logic [0:0] state_hi;
  int n_tests;
  int n_fail;

  pc_next_ctrl_if #(.XLEN(32)) bus ();
  pc_next_ctrl_if #(.XLEN(32)) bus_hi ();

  pc_next_ctrl #(.XLEN(32), .RESET_PC(32'h0000_0000), .FLUSH_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .bus(bus), .state_o(state_lo)
  );

  pc_next_ctrl #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .FLUSH_CYCLES(2)) u_dut_hi (
    .clk(clk), .rst(rst_hi), .bus(bus_hi), .state_o(state_hi)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.stall = 1'b0; bus.imem_ready = 1'b1; bus.pc_src = 1'b0;
    bus.branch_target = '0;
    #1;
    n_tests++; if (bus.imem_req !== 1'b0) begin $display("FAIL reset_req_pre got=%b exp=0", bus.imem_req); n_fail++; end
    tick();
    n_tests++; if (bus.pc !== 32'h0) begin $display("FAIL reset_pc got=%h exp=00000000", bus.pc); n_fail++; end
    n_tests++; if (bus.flush !== 1'b0) begin $display("FAIL reset_flush got=%b exp=0", bus.flush); n_fail++; end
    n_tests++; if (bus.misalign !== 1'b0) begin $display("FAIL reset_misalign got=%b exp=0", bus.misalign); n_fail++; end
    n_tests++; if (bus.redirect_cnt !== 16'd0) begin $display("FAIL reset_rcnt got=%0d exp=0", bus.redirect_cnt); n_fail++; end
    n_tests++; if (bus.imem_req !== 1'b0) begin $display("FAIL reset_req got=%b exp=0", bus.imem_req); n_fail++; end
    tick();
    n_tests++; if (bus.pc !== 32'h0) begin $display("FAIL reset_pc2 got=%h exp=00000000", bus.pc); n_fail++; end
    rst = 1'b0;
    #1;
    n_tests++; if (bus.imem_req !== 1'b1) begin $display("FAIL post_reset_req got=%b exp=1", bus.imem_req); n_fail++; end
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_tests++; if (bus.pc !== 32'(i * 4)) begin $display("FAIL seq_pc[%0d] got=%h exp=%h", i, bus.pc, 32'(i * 4)); n_fail++; end
      n_tests++; if (bus.flush !== 1'b0) begin $display("FAIL seq_flush[%0d] got=%b exp=0", i, bus.flush); n_fail++; end
    end
  endtask

  task automatic test_handshake_hold();
    tick();
    n_tests++; if (bus.pc !== 32'h10) begin $display("FAIL hs_start_pc got=%h exp=00000010", bus.pc); n_fail++; end
    bus.imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (bus.imem_req !== 1'b1) begin $display("FAIL notready_req[%0d] got=%b exp=1", i, bus.imem_req); n_fail++; end
      tick();
      n_tests++; if (bus.pc !== 32'h10) begin $display("FAIL notready_pc[%0d] got=%h exp=00000010", i, bus.pc); n_fail++; end
    end
    bus.imem_ready = 1'b1; bus.stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_tests++; if (bus.imem_req !== 1'b0) begin $display("FAIL stall_req[%0d] got=%b exp=0", i, bus.imem_req); n_fail++; end
      tick();
      n_tests++; if (bus.pc !== 32'h10) begin $display("FAIL stall_pc[%0d] got=%h exp=00000010", i, bus.pc); n_fail++; end
    end
    bus.stall = 1'b0;
    tick();
    n_tests++; if (bus.pc !== 32'h14) begin $display("FAIL accept_pc got=%h exp=00000014", bus.pc); n_fail++; end
  endtask

  task automatic test_redirect_stall();
    tick(); tick(); tick();
    n_tests++; if (bus.pc !== 32'h20) begin $display("FAIL pre_redirect_pc got=%h exp=00000020", bus.pc); n_fail++; end
    bus.stall = 1'b1; bus.pc_src = 1'b1; bus.branch_target = 32'h100;
    tick();
    bus.stall = 1'b0; bus.pc_src = 1'b0; bus.branch_target = 32'hDEAD_BEEF;
    #1;
    n_tests++; if (bus.pc !== 32'h100) begin $display("FAIL redir_pc got=%h exp=00000100", bus.pc); n_fail++; end
    n_tests++; if (bus.flush !== 1'b1) begin $display("FAIL redir_flush1 got=%b exp=1", bus.flush); n_fail++; end
    n_tests++; if (bus.imem_req !== 1'b0) begin $display("FAIL redir_req1 got=%b exp=0", bus.imem_req); n_fail++; end
    n_tests++; if (bus.redirect_cnt !== 16'd1) begin $display("FAIL redir_rcnt got=%0d exp=1", bus.redirect_cnt); n_fail++; end
    n_tests++; if (state_lo !== 1'b1) begin $display("FAIL redir_state got=%b exp=1", state_lo); n_fail++; end
    tick();
    n_tests++; if (bus.flush !== 1'b1) begin $display("FAIL redir_flush2 got=%b exp=1", bus.flush); n_fail++; end
    n_tests++; if (bus.imem_req !== 1'b0) begin $display("FAIL redir_req2 got=%b exp=0", bus.imem_req); n_fail++; end
    n_tests++; if (bus.pc !== 32'h100) begin $display("FAIL redir_pc2 got=%h exp=00000100", bus.pc); n_fail++; end
    tick();
    n_tests++; if (bus.flush !== 1'b0) begin $display("FAIL redir_flush3 got=%b exp=0", bus.flush); n_fail++; end
    n_tests++; if (bus.imem_req !== 1'b1) begin $display("FAIL redir_req3 got=%b exp=1", bus.imem_req); n_fail++; end
    n_tests++; if (bus.pc !== 32'h100) begin $display("FAIL target_fetch_pc got=%h exp=00000100", bus.pc); n_fail++; end
    tick();
    n_tests++; if (bus.pc !== 32'h104) begin $display("FAIL target_next_pc got=%h exp=00000104", bus.pc); n_fail++; end
  endtask

  task automatic test_ignore_in_flush();
    // Redirect taken while a transfer is also possible: redirect must win.
    bus.pc_src = 1'b1; bus.branch_target = 32'h200;
    tick();
    n_tests++; if (bus.pc !== 32'h200) begin $display("FAIL ign_pc got=%h exp=00000200", bus.pc); n_fail++; end
    bus.branch_target = 32'h300;
    tick();
    bus.pc_src = 1'b0;
    #1;
    n_tests++; if (bus.pc !== 32'h200) begin $display("FAIL ign_pc2 got=%h exp=00000200", bus.pc); n_fail++; end
    n_tests++; if (bus.flush !== 1'b1) begin $display("FAIL ign_flush2 got=%b exp=1", bus.flush); n_fail++; end
    n_tests++; if (bus.redirect_cnt !== 16'd2) begin $display("FAIL ign_rcnt got=%0d exp=2", bus.redirect_cnt); n_fail++; end
    tick();
    n_tests++; if (bus.flush !== 1'b0) begin $display("FAIL ign_flush3 got=%b exp=0", bus.flush); n_fail++; end
    n_tests++; if (bus.pc !== 32'h200) begin $display("FAIL ign_pc3 got=%h exp=00000200", bus.pc); n_fail++; end
    tick();
    n_tests++; if (bus.pc !== 32'h204) begin $display("FAIL ign_pc4 got=%h exp=00000204", bus.pc); n_fail++; end
    n_tests++; if (bus.redirect_cnt !== 16'd2) begin $display("FAIL ign_rcnt2 got=%0d exp=2", bus.redirect_cnt); n_fail++; end
  endtask

  task automatic test_misalign();
    bus.pc_src = 1'b1; bus.branch_target = 32'h103;
    tick();
    bus.pc_src = 1'b0;
    #1;
    n_tests++; if (bus.pc !== 32'h100) begin $display("FAIL mis_pc got=%h exp=00000100", bus.pc); n_fail++; end
    n_tests++; if (bus.misalign !== 1'b1) begin $display("FAIL mis_pulse got=%b exp=1", bus.misalign); n_fail++; end
    tick();
    n_tests++; if (bus.misalign !== 1'b0) begin $display("FAIL mis_clear got=%b exp=0", bus.misalign); n_fail++; end
    tick();
    n_tests++; if (bus.redirect_cnt !== 16'd3) begin $display("FAIL mis_rcnt got=%0d exp=3", bus.redirect_cnt); n_fail++; end
    bus.pc_src = 1'b1; bus.branch_target = 32'h400;
    tick();
    bus.pc_src = 1'b0;
    #1;
    n_tests++; if (bus.pc !== 32'h400) begin $display("FAIL al_pc got=%h exp=00000400", bus.pc); n_fail++; end
    n_tests++; if (bus.misalign !== 1'b0) begin $display("FAIL al_misalign got=%b exp=0", bus.misalign); n_fail++; end
    n_tests++; if (bus.redirect_cnt !== 16'd4) begin $display("FAIL al_rcnt got=%0d exp=4", bus.redirect_cnt); n_fail++; end
    tick(); tick();
  endtask

  task automatic test_wrap_and_reset_in_flush();
    bus_hi.stall = 1'b0; bus_hi.imem_ready = 1'b1; bus_hi.pc_src = 1'b0;
    bus_hi.branch_target = '0;
    rst_hi = 1'b1;
    tick();
    n_tests++; if (bus_hi.pc !== 32'hFFFF_FFF8) begin $display("FAIL wrap_reset_pc got=%h exp=fffffff8", bus_hi.pc); n_fail++; end
    rst_hi = 1'b0;
    tick();
    n_tests++; if (bus_hi.pc !== 32'hFFFF_FFFC) begin $display("FAIL wrap_pc1 got=%h exp=fffffffc", bus_hi.pc); n_fail++; end
    tick();
    n_tests++; if (bus_hi.pc !== 32'h0) begin $display("FAIL wrap_pc2 got=%h exp=00000000", bus_hi.pc); n_fail++; end
    bus_hi.pc_src = 1'b1; bus_hi.branch_target = 32'h500;
    tick();
    bus_hi.pc_src = 1'b0;
    #1;
    n_tests++; if (bus_hi.flush !== 1'b1) begin $display("FAIL rif_flush got=%b exp=1", bus_hi.flush); n_fail++; end
    rst_hi = 1'b1;
    #1;
    n_tests++; if (bus_hi.imem_req !== 1'b0) begin $display("FAIL rif_req got=%b exp=0", bus_hi.imem_req); n_fail++; end
    tick();
    n_tests++; if (bus_hi.flush !== 1'b0) begin $display("FAIL rif_flush2 got=%b exp=0", bus_hi.flush); n_fail++; end
    n_tests++; if (bus_hi.pc !== 32'hFFFF_FFF8) begin $display("FAIL rif_pc got=%h exp=fffffff8", bus_hi.pc); n_fail++; end
    n_tests++; if (state_hi !== 1'b0) begin $display("FAIL rif_state got=%b exp=0", state_hi); n_fail++; end
    n_tests++; if (bus_hi.redirect_cnt !== 16'd0) begin $display("FAIL rif_rcnt got=%0d exp=0", bus_hi.redirect_cnt); n_fail++; end
    rst_hi = 1'b0;
    tick();
    n_tests++; if (bus_hi.pc !== 32'hFFFF_FFFC) begin $display("FAIL rif_resume got=%h exp=fffffffc", bus_hi.pc); n_fail++; end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_hi = 1'b1;
    bus_hi.stall = 1'b0; bus_hi.imem_ready = 1'b0; bus_hi.pc_src = 1'b0;
    bus_hi.branch_target = '0;
    test_reset();
    test_handshake_hold();
    test_redirect_stall();
    test_ignore_in_flush();
    test_misalign();
    test_wrap_and_reset_in_flush();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_next_ctrl.md
Name: pc_next_ctrl

Overview:
- Owns the program counter and consumes the taken-branch decision (pc_src) produced at the branch-resolution end of the datapath.
- Issues sequential instruction-fetch requests to instruction memory over a valid/ready handshake.
- On a taken branch, redirects the PC to the branch target and asserts a multi-cycle flush that kills wrong-path instructions in IF/ID.
- Sits between the branch-decision logic in EX and the instruction-memory port in IF.

Parameters:
XLEN, 32, PC and target width in bits.
RESET_PC, 32'h0000_0000, PC value loaded on reset.
FLUSH_CYCLES, 2, number of cycles flush stays high after a redirect. Legal range is 1 to 15.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
stall  in  1  hazard stall from the pipeline; blocks sequential PC advance.
pc_src  in  1  taken-branch decision from EX (branch AND zero).
branch_target  in  XLEN  redirect address, sampled when pc_src=1.
imem_ready  in  1  instruction memory accepts the request this cycle.
pc  out  XLEN  current fetch address; registered.
imem_req  out  1  fetch request valid; combinational from state, stall and rst.
flush  out  1  kill IF/ID contents; registered.
misalign  out  1  one-cycle pulse, registered: the accepted target had [1:0] != 0.
redirect_cnt  out  16  count of accepted redirects; wraps at 16'hFFFF -> 0.

Behaviour:
- Reset: one clock with rst=1 sets pc=RESET_PC, state=RUN, flush=0, misalign=0, redirect_cnt=0, flush counter=0. imem_req=0 in any cycle where rst=1. rst overrides every other input, including a redirect in progress.
- States: RUN (normal fetch) and FLUSH (bubble insertion).
- Output per state:
  - imem_req = (state==RUN) && !stall && !rst.
  - flush = 1 exactly while state==FLUSH.
- Transfer: a fetch transfer occurs when imem_req && imem_ready.
- RUN, priority order evaluated each cycle:
  1. pc_src=1 → redirect.
     - Next cycle: pc = {branch_target[XLEN-1:2], 2'b00}, state=FLUSH, flush counter=FLUSH_CYCLES-1, redirect_cnt+1.
     - misalign=1 for one cycle if branch_target[1:0] != 0.
     - Redirect wins over stall, and over a transfer in the same cycle. The fetch of the old pc is discarded; the downstream stage must honour flush.
  2. Else if transfer → pc = pc + 4, truncated to XLEN bits. 0xFFFF_FFFC wraps to 0x0000_0000.
  3. Else (stall, or imem_ready=0) → pc holds. imem_req stays high while !stall, and pc stays stable until accepted.
- FLUSH:
  - imem_req=0; pc holds the target.
  - pc_src is ignored, because it comes from a wrong-path instruction being killed. redirect_cnt and misalign are unaffected.
  - Counter decrements each cycle. When the counter is 0, the next state is RUN.
  - flush is high for exactly FLUSH_CYCLES cycles, starting the cycle after pc_src is sampled.
- Latency:
  - pc_src to new pc: 1 cycle.
  - First fetch of the target is requested FLUSH_CYCLES+1 cycles after pc_src, provided stall=0.
- stall has no effect on the FLUSH countdown.
- misalign is cleared to 0 on every cycle it is not being pulsed.

Test Plan:
1. rst=1 for 2 cycles, then release with stall=0, imem_ready=1 → pc=0x0, then 0x4, 0x8, 0xC on successive cycles; imem_req=0 during reset; flush=0 throughout.
2. Sequential fetch at pc=0x10, then imem_ready=0 for 3 cycles, then stall=1 for 2 cycles → pc holds 0x10; imem_req is high during the not-ready cycles and low during the stall; pc advances to 0x14 on the first accepted transfer.
3. pc_src=1 with branch_target=0x100, asserted together with stall=1 at pc=0x20 → next cycle pc=0x100; flush high for exactly 2 cycles; imem_req low for those 2 cycles; redirect_cnt=1; then fetch of 0x100, then 0x104.
4. Redirect to 0x200, then pc_src=1 with target 0x300 during the first flush cycle → ignored; pc stays 0x200; redirect_cnt increments only once.
5. branch_target=0x103 → pc=0x100 and a one-cycle misalign pulse; a following aligned redirect leaves misalign=0.
6. RESET_PC=0xFFFF_FFF8 with continuous transfers → pc goes 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000. Separately, rst asserted in the middle of FLUSH → state=RUN, flush=0 and pc=RESET_PC on the next cycle.
